four_bit_adder_sub: RTL and testbench

- 4-bit adder/subtractor with one registered output stage.
- Built as a ripple-carry chain of full adders, with operand-B inversion for subtraction (two's complement: A + ~B + 1).
- Serves as a small ALU arithmetic slice; its y/cf outputs feed downstream datapath and flag logic.

---
 rtl/four_bit_adder_sub_pkg.sv | 14 +
 rtl/four_bit_adder_sub_full_adder.sv | 13 +
 rtl/four_bit_adder_sub.sv | 70 +++++++
 tb/tb_four_bit_adder_sub.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/four_bit_adder_sub_pkg.sv
// Shared constants and op decode for the 4-bit adder/subtractor slice.
package four_bit_adder_sub_pkg;

  localparam int WIDTH = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  // Every code other than ADD selects subtraction, so 10 and 11 alias SUB.
  function automatic logic op_is_sub(input logic [1:0] op);
    return (op != OP_ADD);
  endfunction

endpackage

// File: rtl/four_bit_adder_sub_full_adder.sv
// Single-bit full adder; one link of the ripple-carry chain.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/four_bit_adder_sub.sv
// Ripple-carry adder/subtractor with a single registered result stage.
module four_bit_adder_sub #(
  parameter int WIDTH = four_bit_adder_sub_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             cf,
  output logic             out_valid
);

  import four_bit_adder_sub_pkg::*;

  logic             sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   c;

  logic [WIDTH-1:0] y_q, y_d;
  logic             cf_q, cf_d;
  logic             vld_q, vld_d;

  // Two's complement subtract: invert B and inject the +1 as carry-in.
  assign sub  = op_is_sub(op);
  assign bx   = b ^ {WIDTH{sub}};
  assign c[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a_i    (a[i]),
      .b_i    (bx[i]),
      .cin_i  (c[i]),
      .s_o    (s[i]),
      .cout_o (c[i+1])
    );
  end

  always_comb begin
    y_d   = y_q;
    cf_d  = cf_q;
    vld_d = 1'b0;
    if (in_valid) begin
      y_d   = s;
      cf_d  = c[WIDTH];
      vld_d = 1'b1;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      cf_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      cf_q  <= cf_d;
      vld_q <= vld_d;
    end
  end

  assign y         = y_q;
  assign cf        = cf_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_four_bit_adder_sub.sv
// Scoreboard bench for four_bit_adder_sub: stimulus pushes expected results, a negedge monitor pops and checks.
module tb_four_bit_adder_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] op;
  logic       in_valid;
  logic [3:0] y;
  logic       cf;
  logic       out_valid;

  typedef struct packed {
    logic [3:0] y;
    logic       cf;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  four_bit_adder_sub dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_valid  (in_valid),
    .y         (y),
    .cf        (cf),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; a captured op (valid, not in reset) enqueues its expected result.
  task automatic step(input logic r, input logic v, input logic [3:0] ta, input logic [3:0] tb,
                      input logic [1:0] top, input logic [3:0] ey, input logic ecf);
    exp_t x;
    rst      = r;
    in_valid = v;
    a        = ta;
    b        = tb;
    op       = top;
    @(posedge clk);
    if (v && !r) begin
      x.y  = ey;
      x.cf = ecf;
      q.push_back(x);
    end
    #1;
  endtask

  // Monitor: exactly one result per captured op, one cycle later; otherwise out_valid must be low.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_valid", {7'd0, out_valid}, 8'd1);
        chk("y", {4'd0, y}, {4'd0, e.y});
        chk("cf", {7'd0, cf}, {7'd0, e.cf});
      end else begin
        chk("out_valid_idle", {7'd0, out_valid}, 8'd0);
      end
    end
  end

  initial begin
    int s;
    logic [3:0] ey;
    logic       ecf;

    // Reset with a valid op present: must not be captured.
    step(1'b1, 1'b1, 4'd3, 4'd2, 2'b00, 4'd0, 1'b0);
    mon_en = 1'b1;
    step(1'b1, 1'b1, 4'd3, 4'd2, 2'b00, 4'd0, 1'b0);
    chk("rst_y", {4'd0, y}, 8'd0);
    chk("rst_cf", {7'd0, cf}, 8'd0);
    chk("rst_vld", {7'd0, out_valid}, 8'd0);

    // ADD
    step(1'b0, 1'b1, 4'd3,  4'd2, 2'b00, 4'd5,  1'b0);
    step(1'b0, 1'b1, 4'd15, 4'd1, 2'b00, 4'd0,  1'b1);
    step(1'b0, 1'b1, 4'd7,  4'd7, 2'b00, 4'd14, 1'b0);
    // SUB
    step(1'b0, 1'b1, 4'd8,  4'd3, 2'b01, 4'd5,  1'b1);
    step(1'b0, 1'b1, 4'd5,  4'd5, 2'b01, 4'd0,  1'b1);
    step(1'b0, 1'b1, 4'd3,  4'd5, 2'b01, 4'd14, 1'b0);
    // Op aliasing
    step(1'b0, 1'b1, 4'd8,  4'd3, 2'b10, 4'd5,  1'b1);
    step(1'b0, 1'b1, 4'd8,  4'd3, 2'b11, 4'd5,  1'b1);

    // Reset arriving with a new op: result discarded, registers cleared.
    step(1'b1, 1'b1, 4'd9,  4'd4, 2'b00, 4'd0,  1'b0);
    chk("midrst_y", {4'd0, y}, 8'd0);
    chk("midrst_cf", {7'd0, cf}, 8'd0);
    step(1'b0, 1'b0, 4'd9,  4'd4, 2'b00, 4'd0,  1'b0);
    chk("midrst_vld", {7'd0, out_valid}, 8'd0);

    // Hold: 0-1 then idle cycles with changing operands.
    step(1'b0, 1'b1, 4'd0,  4'd1, 2'b01, 4'd15, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'(i + 2), 4'(9 - i), 2'b00, 4'd0, 1'b0);
      chk("hold_y", {4'd0, y}, 8'd15);
      chk("hold_cf", {7'd0, cf}, 8'd0);
      chk("hold_vld", {7'd0, out_valid}, 8'd0);
    end

    // Exhaustive back-to-back, expectations from plain integer arithmetic.
    for (int k = 0; k < 2; k++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          if (k == 0) begin
            s   = ai + bi;
            ey  = 4'(s % 16);
            ecf = (s > 15);
          end else begin
            s   = ai - bi + 16;
            ey  = 4'(s % 16);
            ecf = (ai >= bi);
          end
          step(1'b0, 1'b1, 4'(ai), 4'(bi), (k == 0) ? 2'b00 : 2'b01, ey, ecf);
        end
      end
    end

    step(1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0);
    chk("drain", 8'(q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
